// File: rtl/matmul_buffer_pkg.sv
// ----------------------------------------------------------------------------
// matmul_buffer_pkg
// Shared definitions for the operand-buffer write path: default widths used
// by both buffer_write_controller and buffer_write_address_generator, the
// controller state type and a helper that turns an address width into the
// number of buffer entries.
// ----------------------------------------------------------------------------
package matmul_buffer_pkg;

    // Defaults shared with the paired address generator so both sides of the
    // address bus agree unless a parent overrides them together.
    localparam int DEFAULT_DATA_WIDTH           = 16;
    localparam int DEFAULT_BUFFER_ADDRESS_WIDTH = 10;
    localparam int DEFAULT_DIM_WIDTH            = 8;

    // Width of the element counter and of the rows*cols product.
    localparam int COUNT_WIDTH = 16;

    // Load controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } writeState_e;

    // Number of addressable buffer entries for a given address width.
    function automatic int unsigned bufferDepth(input int unsigned addrWidth);
        return 32'd1 << addrWidth;
    endfunction

endpackage

// File: rtl/buffer_write_controller.sv
// ----------------------------------------------------------------------------
// buffer_write_controller
// Upstream stage of buffer_write_address_generator. Accepts a matrix element
// stream over valid/ready and writes each element into the operand buffer at
// the address presented by the generator, one cycle after acceptance. Loads
// rows*cols elements, then holds done_o until acknowledged.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start_i         one-cycle pulse; samples rows_i/cols_i and begins a load
//   abort_i         abandons the current load
//   done_ack_i      acknowledges done_o
//   rows_i, cols_i  matrix dimensions, sampled on start_i
//   s_valid_i/s_data_i/s_ready_o   element stream handshake
//   address_i       current write address from the generator
//   count_up_o      generator increment (one per accepted element)
//   clear_o         generator clear (one-cycle registered pulse)
//   wr_en_o/wr_addr_o/wr_data_o    buffer write port
//   busy_o, done_o  state indications (LOAD, DONE)
//   size_err_o      one-cycle pulse when a start request has an illegal size
//   elem_count_o    elements accepted in the current load
// ----------------------------------------------------------------------------
module buffer_write_controller
    import matmul_buffer_pkg::*;
#(
    parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
    parameter int BUFFER_ADDRESS_WIDTH = DEFAULT_BUFFER_ADDRESS_WIDTH,
    parameter int DIM_WIDTH            = DEFAULT_DIM_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic                            done_ack_i,
    input  logic [DIM_WIDTH-1:0]            rows_i,
    input  logic [DIM_WIDTH-1:0]            cols_i,
    input  logic                            s_valid_i,
    input  logic [DATA_WIDTH-1:0]           s_data_i,
    output logic                            s_ready_o,
    input  logic [BUFFER_ADDRESS_WIDTH-1:0] address_i,
    output logic                            count_up_o,
    output logic                            clear_o,
    output logic                            wr_en_o,
    output logic [BUFFER_ADDRESS_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0]           wr_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            size_err_o,
    output logic [COUNT_WIDTH-1:0]          elem_count_o
);

    localparam int unsigned DEPTH = bufferDepth(BUFFER_ADDRESS_WIDTH);
    localparam int          PAD   = COUNT_WIDTH - DIM_WIDTH;

    writeState_e                     state_q;
    logic [COUNT_WIDTH-1:0]          total_q;
    logic [COUNT_WIDTH-1:0]          elemCount_q;
    logic [COUNT_WIDTH-1:0]          elemCount_d;
    logic                            clear_q;
    logic                            sizeErr_q;
    logic                            wrEn_q;
    logic [BUFFER_ADDRESS_WIDTH-1:0] wrAddr_q;
    logic [DATA_WIDTH-1:0]           wrData_q;

    logic [COUNT_WIDTH-1:0]          rowsExt;
    logic [COUNT_WIDTH-1:0]          colsExt;
    logic [COUNT_WIDTH-1:0]          requestedTotal;
    logic                            sizeOk;
    logic                            accept;

    // Size check for a start request. Both dimensions fit in half the
    // counter width, so the 16-bit product cannot overflow.
    always_comb begin
        rowsExt        = {{PAD{1'b0}}, rows_i};
        colsExt        = {{PAD{1'b0}}, cols_i};
        requestedTotal = rowsExt * colsExt;
        sizeOk         = (requestedTotal != '0) && (32'(requestedTotal) <= DEPTH);
    end

    // Handshake: ready only while loading with elements still owed, and
    // abort suppresses ready so an abort always beats a same-cycle beat.
    // The generator steps on exactly the accepted beats.
    always_comb begin
        s_ready_o   = (state_q == LOAD) && !abort_i && (elemCount_q < total_q);
        accept      = s_valid_i && s_ready_o;
        count_up_o  = accept;
        elemCount_d = elemCount_q + 1'b1;
    end

    // Single state machine with registered pulse outputs. The write port
    // captures address and data on accept and issues one cycle later, so the
    // final write of a load lands in the first DONE cycle and a write in
    // flight when abort arrives still completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            total_q     <= '0;
            elemCount_q <= '0;
            clear_q     <= 1'b0;
            sizeErr_q   <= 1'b0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
        end else begin
            clear_q   <= 1'b0;
            sizeErr_q <= 1'b0;
            wrEn_q    <= accept;
            if (accept) begin
                wrAddr_q <= address_i;
                wrData_q <= s_data_i;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        if (sizeOk) begin
                            total_q     <= requestedTotal;
                            elemCount_q <= '0;
                            clear_q     <= 1'b1;
                            state_q     <= LOAD;
                        end else begin
                            sizeErr_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else if (state_q == DONE && done_ack_i) begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        clear_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (accept) begin
                        elemCount_q <= elemCount_d;
                        if (elemCount_d == total_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy_o       = (state_q == LOAD);
        done_o       = (state_q == DONE);
        clear_o      = clear_q;
        size_err_o   = sizeErr_q;
        wr_en_o      = wrEn_q;
        wr_addr_o    = wrAddr_q;
        wr_data_o    = wrData_q;
        elem_count_o = elemCount_q;
    end

endmodule

// File: tb/tb_buffer_write_controller.sv
// ----------------------------------------------------------------------------
// tb_buffer_write_controller
// Self-checking bench for buffer_write_controller. A simple address generator
// sits beside the DUT as the parent would place it; expected writes are the
// k-th element of a load at address k, queued as the bench offers them.
// ----------------------------------------------------------------------------
module tb_buffer_write_controller;
    import matmul_buffer_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int AW = DEFAULT_BUFFER_ADDRESS_WIDTH;
    localparam int NW = DEFAULT_DIM_WIDTH;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } writeT;

    logic          clk;
    logic          reset;
    logic          startIn;
    logic          abortIn;
    logic          doneAck;
    logic [NW-1:0] rowsIn;
    logic [NW-1:0] colsIn;
    logic          sValid;
    logic [DW-1:0] sData;
    logic          sReady;
    logic [AW-1:0] genCount;
    logic          countUp;
    logic          clearOut;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          busy;
    logic          done;
    logic          sizeErr;
    logic [15:0]   elemCount;

    int    vectors     = 0;
    int    miscompares = 0;
    int    sentInLoad  = 0;
    int    countUpSeen = 0;
    writeT expWrites[$];

    buffer_write_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (startIn),
        .abort_i      (abortIn),
        .done_ack_i   (doneAck),
        .rows_i       (rowsIn),
        .cols_i       (colsIn),
        .s_valid_i    (sValid),
        .s_data_i     (sData),
        .s_ready_o    (sReady),
        .address_i    (genCount),
        .count_up_o   (countUp),
        .clear_o      (clearOut),
        .wr_en_o      (wrEn),
        .wr_addr_o    (wrAddr),
        .wr_data_o    (wrData),
        .busy_o       (busy),
        .done_o       (done),
        .size_err_o   (sizeErr),
        .elem_count_o (elemCount)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the neighbouring address generator: increment wins over
    // clear when both arrive together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            genCount <= '0;
        end else if (countUp) begin
            genCount <= genCount + 1'b1;
        end else if (clearOut) begin
            genCount <= '0;
        end
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Write-port monitor on the falling edge: every write must be the next
    // element the bench offered, at its position within the load.
    always @(negedge clk) begin
        if (!reset) begin
            if (countUp) countUpSeen++;
            if (wrEn) begin
                if (expWrites.size() == 0) begin
                    checkOutput("unexpectedWrite", 32'(wrAddr), 32'hFFFF_FFFF);
                end else begin
                    writeT w;
                    w = expWrites.pop_front();
                    checkOutput("wrAddr", 32'(wrAddr), 32'(w.addr));
                    checkOutput("wrData", 32'(wrData), 32'(w.data));
                end
            end
        end
    end

    // Pulse start_i (optionally with done_ack_i) and check the response.
    // A legal start is followed by one quiet cycle so the generator clear
    // lands before the stream begins.
    task automatic applyStimulus(input int rows, input int cols, input logic withAck);
        int  total;
        bit  legal;
        total   = rows * cols;
        legal   = (total != 0) && (total <= (1 << AW));
        rowsIn  = NW'(rows);
        colsIn  = NW'(cols);
        startIn = 1'b1;
        doneAck = withAck;
        @(posedge clk); #1;
        startIn = 1'b0;
        doneAck = 1'b0;
        if (legal) begin
            checkOutput("startClear", 32'(clearOut), 32'd1);
            checkOutput("startBusy", 32'(busy), 32'd1);
            checkOutput("startSizeErr", 32'(sizeErr), 32'd0);
            checkOutput("startCount", 32'(elemCount), 32'd0);
            sentInLoad = 0;
            @(posedge clk); #1;
            checkOutput("clearOneCycle", 32'(clearOut), 32'd0);
        end else begin
            checkOutput("sizeErrPulse", 32'(sizeErr), 32'd1);
            checkOutput("sizeErrNoClear", 32'(clearOut), 32'd0);
            checkOutput("sizeErrIdle", 32'(busy), 32'd0);
            @(posedge clk); #1;
            checkOutput("sizeErrOneCycle", 32'(sizeErr), 32'd0);
            checkOutput("sizeErrStillIdle", 32'(busy), 32'd0);
        end
    endtask

    // Offer n elements with a gapPct chance of an idle cycle before each.
    task automatic streamElements(input int n, input int gapPct);
        int k;
        int budget;
        logic v;
        k      = 0;
        budget = n * 40 + 10;
        while (k < n && budget > 0) begin
            budget--;
            v      = ($urandom_range(99) >= gapPct);
            sValid = v;
            sData  = DW'($urandom);
            #1;
            checkOutput("sReady", 32'(sReady), 32'd1);
            checkOutput("countUp", 32'(countUp), 32'(v));
            if (v) begin
                expWrites.push_back('{addr: AW'(sentInLoad), data: sData});
                sentInLoad++;
                k++;
            end
            @(posedge clk); #1;
            sValid = 1'b0;
            if (budget == 0 || k == n || ($urandom_range(7) == 0))
                checkOutput("elemCount", 32'(elemCount), 32'(sentInLoad));
        end
        if (k < n) checkOutput("streamBudget", 32'(k), 32'(n));
    endtask

    // Load just completed: DONE refuses data, then acknowledge back to IDLE.
    task automatic finishLoad(input int total);
        checkOutput("doneHigh", 32'(done), 32'd1);
        checkOutput("doneNotBusy", 32'(busy), 32'd0);
        checkOutput("doneCount", 32'(elemCount), 32'(total));
        sValid = 1'b1;
        #1;
        checkOutput("doneNoReady", 32'(sReady), 32'd0);
        checkOutput("doneNoCountUp", 32'(countUp), 32'd0);
        sValid  = 1'b0;
        doneAck = 1'b1;
        @(posedge clk); #1;
        doneAck = 1'b0;
        checkOutput("ackIdle", 32'(done), 32'd0);
        checkOutput("ackNotBusy", 32'(busy), 32'd0);
        checkOutput("pendingWrites", 32'(expWrites.size()), 32'd0);
    endtask

    initial begin
        int upBefore;
        reset = 1'b1; startIn = 1'b0; abortIn = 1'b0; doneAck = 1'b0;
        rowsIn = '0; colsIn = '0; sValid = 1'b0; sData = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstWrEn", 32'(wrEn), 32'd0);
        checkOutput("rstClear", 32'(clearOut), 32'd0);
        checkOutput("rstCount", 32'(elemCount), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] 3x4 load, valid every cycle");
        upBefore = countUpSeen;
        applyStimulus(3, 4, 1'b0);
        streamElements(12, 0);
        finishLoad(12);
        checkOutput("countUpTotal", 32'(countUpSeen - upBefore), 32'd12);

        $display("[TB] illegal sizes, then largest legal size");
        applyStimulus(0, 5, 1'b0);
        applyStimulus(32, 33, 1'b0);
        applyStimulus(32, 32, 1'b0);
        streamElements(1024, 0);
        finishLoad(1024);

        $display("[TB] 2x2 load with random gaps");
        applyStimulus(2, 2, 1'b0);
        streamElements(4, 50);
        finishLoad(4);

        $display("[TB] abort on element 3 of 6");
        applyStimulus(2, 3, 1'b0);
        streamElements(2, 0);
        sValid  = 1'b1;
        abortIn = 1'b1;
        sData   = DW'($urandom);
        #1;
        checkOutput("abortNoReady", 32'(sReady), 32'd0);
        checkOutput("abortNoCountUp", 32'(countUp), 32'd0);
        @(posedge clk); #1;
        sValid  = 1'b0;
        abortIn = 1'b0;
        checkOutput("abortIdle", 32'(busy), 32'd0);
        checkOutput("abortClear", 32'(clearOut), 32'd1);
        checkOutput("abortNotDone", 32'(done), 32'd0);
        applyStimulus(2, 2, 1'b0);
        streamElements(4, 0);
        finishLoad(4);

        $display("[TB] start and done_ack together in DONE");
        applyStimulus(1, 3, 1'b0);
        streamElements(3, 30);
        checkOutput("doneBeforeRestart", 32'(done), 32'd1);
        applyStimulus(2, 3, 1'b1);
        streamElements(6, 30);
        finishLoad(6);

        $display("[TB] random dimension loads");
        for (int i = 0; i < 6; i++) begin
            int r;
            int c;
            r = $urandom_range(1, 5);
            c = $urandom_range(1, 5);
            applyStimulus(r, c, 1'b0);
            streamElements(r * c, 50);
            finishLoad(r * c);
        end

        $display("[TB] reset in the middle of a load");
        applyStimulus(3, 4, 1'b0);
        streamElements(5, 0);
        reset = 1'b1;
        #1;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        checkOutput("midRstWrEn", 32'(wrEn), 32'd0);
        checkOutput("midRstCount", 32'(elemCount), 32'd0);
        expWrites.delete();
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        sValid = 1'b1;
        sData  = DW'($urandom);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("postRstNoReady", 32'(sReady), 32'd0);
            @(posedge clk); #1;
            checkOutput("postRstNoWrite", 32'(wrEn), 32'd0);
        end
        sValid = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
